// File: rtl/vg8020_ram_pkg.sv
// Shared constants and encodings for the VG8020 RAM subsystem address path.
package vg8020_ram_pkg;

  // CPU address width and multiplexed DRAM address width.
  // ADDR_W is always exactly twice RC_W: one row half plus one column half.
  localparam int ADDR_W = 16;
  localparam int RC_W   = 8;

  // Encoding of the mux select driven by the RAS/CAS sequencer.
  typedef enum logic {
    MUX_ROW = 1'b0,  // low byte of addr
    MUX_COL = 1'b1   // high byte of addr
  } mux_sel_e;

endpackage

// File: rtl/dram_rowcol_selector_refresh_counter.sv
// Refresh-row counter: free-running up-counter that steps once per
// completed refresh cycle and wraps naturally at 2**RC_W.
module refresh_counter
  import vg8020_ram_pkg::*;
#(
  parameter int RC_W = vg8020_ram_pkg::RC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [RC_W-1:0] count
);

  localparam logic [RC_W-1:0] ONE = {{(RC_W-1){1'b0}}, 1'b1};

  // Count up on each enabled edge; asynchronous reset dominates, so an
  // enable that arrives while reset is held is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dram_rowcol_selector.sv
// DRAM row/column address multiplexer for the VG8020 RAM subsystem.
// Presents the row half, the column half of the CPU address, or the refresh
// row counter on the multiplexed DRAM address bus, plus a registered copy
// of that bus for consumers that need a clean flop output.
module dram_rowcol_selector
  import vg8020_ram_pkg::*;
#(
  parameter int ADDR_W = vg8020_ram_pkg::ADDR_W,
  parameter int RC_W   = vg8020_ram_pkg::RC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mux,
  input  logic [ADDR_W-1:0] addr,
  input  logic              refresh,
  input  logic              refresh_done,
  output logic [RC_W-1:0]   rowcol,
  output logic [RC_W-1:0]   rowcol_q,
  output logic [RC_W-1:0]   refresh_row
);

  logic [RC_W-1:0] row_half;
  logic [RC_W-1:0] col_half;

  assign row_half = addr[RC_W-1:0];
  assign col_half = addr[ADDR_W-1:RC_W];

  refresh_counter #(
    .RC_W (RC_W)
  ) u_refresh_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (refresh_done),
    .count (refresh_row)
  );

  // Address mux. Refresh takes priority over mux. An unknown mux falls to
  // the default arm so an undriven select shows up as X instead of being
  // silently resolved to one half.
  always_comb begin
    rowcol = '0;
    if (refresh) begin
      rowcol = refresh_row;
    end else begin
      case (mux)
        MUX_ROW: rowcol = row_half;
        MUX_COL: rowcol = col_half;
        default: rowcol = 'x;
      endcase
    end
  end

  // One-cycle registered copy of the bus; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowcol_q <= '0;
    end else begin
      rowcol_q <= rowcol;
    end
  end

endmodule

// File: tb/tb_dram_rowcol_selector.sv
// Directed bench for dram_rowcol_selector: a vector table for the address
// mux and output register, then hand-written sequences for reset, refresh
// counting, wrap-around and the refresh/address handover.
module tb_dram_rowcol_selector;

  logic        clk;
  logic        rst;
  logic        mux;
  logic [15:0] addr;
  logic        refresh;
  logic        refresh_done;
  logic [7:0]  rowcol;
  logic [7:0]  rowcol_q;
  logic [7:0]  refresh_row;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [15:0] addr;
    logic        mux;
    logic [7:0]  exp_rowcol;
  } vec_t;

  vec_t vecs[8];

  dram_rowcol_selector dut (
    .clk          (clk),
    .rst          (rst),
    .mux          (mux),
    .addr         (addr),
    .refresh      (refresh),
    .refresh_done (refresh_done),
    .rowcol       (rowcol),
    .rowcol_q     (rowcol_q),
    .refresh_row  (refresh_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{16'h0F5A, 1'b0, 8'h5A};
    vecs[1] = '{16'h0F5A, 1'b1, 8'h0F};
    vecs[2] = '{16'hA5C3, 1'b0, 8'hC3};
    vecs[3] = '{16'hA5C3, 1'b1, 8'hA5};
    vecs[4] = '{16'hFFFF, 1'b0, 8'hFF};
    vecs[5] = '{16'h0000, 1'b1, 8'h00};
    vecs[6] = '{16'h8001, 1'b0, 8'h01};
    vecs[7] = '{16'h8001, 1'b1, 8'h80};

    rst          = 1'b1;
    mux          = 1'b0;
    addr         = 16'h0F5A;
    refresh      = 1'b0;
    refresh_done = 1'b0;

    // Reset state, with a refresh_done pulse held through reset edges.
    #2;
    check("reset_rowcol_q", rowcol_q, 8'h00);
    check("reset_refresh_row", refresh_row, 8'h00);
    refresh_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_ignored_in_reset", refresh_row, 8'h00);
    check("rowcol_live_in_reset", rowcol, 8'h5A);
    @(negedge clk);
    refresh_done = 1'b0;
    rst = 1'b0;

    // Table-driven mux and register checks.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      addr = vecs[i].addr;
      mux  = vecs[i].mux;
      #1;
      check($sformatf("vec%0d_rowcol", i), rowcol, vecs[i].exp_rowcol);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rowcol_q", i), rowcol_q, vecs[i].exp_rowcol);
    end

    // Asynchronous reset mid-cycle with a nonzero counter.
    @(negedge clk);
    addr = 16'h0F5A;
    mux  = 1'b1;
    refresh_done = 1'b1;
    @(negedge clk);
    refresh_done = 1'b0;
    #1;
    check("pre_rst_refresh_row", refresh_row, 8'h01);
    check("pre_rst_rowcol_q", rowcol_q, 8'h0F);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rowcol_q", rowcol_q, 8'h00);
    check("async_rst_refresh_row", refresh_row, 8'h00);
    check("async_rst_rowcol_col", rowcol, 8'h0F);
    mux = 1'b0;
    #1;
    check("async_rst_rowcol_row", rowcol, 8'h5A);
    @(posedge clk);
    #1;
    check("rst_held_rowcol_q", rowcol_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Refresh mode: three pulses, mux has no effect.
    refresh = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      refresh_done = 1'b1;
      @(negedge clk);
      refresh_done = 1'b0;
    end
    #1;
    check("refresh_row_3", refresh_row, 8'h03);
    check("refresh_rowcol_mux0", rowcol, 8'h03);
    mux = 1'b1;
    #1;
    check("refresh_rowcol_mux1", rowcol, 8'h03);
    mux = 1'b0;

    // Counter steps on the same edge the pulse is seen; old value before it.
    @(negedge clk);
    refresh_done = 1'b1;
    #1;
    check("pulse_before_edge", rowcol, 8'h03);
    @(posedge clk);
    #1;
    check("pulse_after_edge", rowcol, 8'h04);
    check("rowcol_q_old_cnt", rowcol_q, 8'h03);
    @(negedge clk);
    refresh_done = 1'b0;

    // Wrap: 255 pulses from zero give FF, the 256th gives 00.
    rst = 1'b1;
    #1;
    check("wrap_start", refresh_row, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    refresh_done = 1'b1;
    repeat (255) @(negedge clk);
    refresh_done = 1'b0;
    #1;
    check("wrap_255", refresh_row, 8'hFF);
    check("wrap_255_rowcol", rowcol, 8'hFF);
    @(negedge clk);
    refresh_done = 1'b1;
    @(negedge clk);
    refresh_done = 1'b0;
    #1;
    check("wrap_256", refresh_row, 8'h00);

    // Handover from refresh back to the CPU address.
    @(negedge clk);
    refresh = 1'b0;
    mux     = 1'b0;
    addr    = 16'hA5C3;
    #1;
    check("handover_rowcol", rowcol, 8'hC3);
    @(posedge clk);
    #1;
    check("handover_rowcol_q", rowcol_q, 8'hC3);
    check("handover_cnt_hold", refresh_row, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
